insn_loader: RTL and testbench

Boot-time program loader for the RV32I core. It receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written into the instruction memory write port at consecutive word addresses. The core is held in reset until the frame completes with a correct checksum. This is the hardware counterpart of the bench's backdoor preload of `insn_memory.mem`.

---
 rtl/insn_loader.sv | 137 +++++++++++++
 tb/tb_insn_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/insn_loader.sv
// Boot-time program loader: framed byte stream -> instruction memory words.
// Holds the core in reset until a frame with a good checksum is loaded.
module insn_loader #(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_reset_n,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        SYNC, CNT_LO, CNT_HI, DATA, CHECK, DONE, ERR
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MEM_WORDS);

    state_t      state, state_nx;
    logic [15:0] count, word_idx, count_full;
    logic [1:0]  byte_cnt;
    logic [23:0] shreg;
    logic [7:0]  csum;
    logic        take, is_sync, start;
    logic        oversize, empty, last_byte, last_word, csum_ok;

    // The write cycle is the only stall, so ready is simply the inverse strobe.
    assign rx_ready   = !mem_we;
    assign take       = rx_valid && rx_ready;
    assign is_sync    = rx_data == 8'hA5;
    assign count_full = {rx_data, count[7:0]};
    assign oversize   = {1'b0, count_full} > MAX_N;
    assign empty      = count_full == 16'd0;
    assign last_byte  = byte_cnt == 2'd3;
    assign last_word  = (word_idx + 16'd1) == count;
    assign csum_ok    = rx_data == csum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= SYNC;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        if (take) begin
            unique case (state)
                SYNC: begin
                    if (is_sync) begin
                        state_nx = CNT_LO;
                        start    = 1'b1;
                    end
                end
                CNT_LO: state_nx = CNT_HI;
                CNT_HI: begin
                    if (oversize)   state_nx = ERR;
                    else if (empty) state_nx = CHECK;
                    else            state_nx = DATA;
                end
                DATA: begin
                    if (last_byte && last_word) state_nx = CHECK;
                end
                CHECK: state_nx = csum_ok ? DONE : ERR;
                DONE, ERR: begin
                    if (is_sync) begin
                        state_nx = CNT_LO;
                        start    = 1'b1;
                    end
                end
                default: state_nx = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count        <= '0;
            word_idx     <= '0;
            byte_cnt     <= '0;
            shreg        <= '0;
            csum         <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            core_reset_n <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                word_idx     <= '0;
                csum         <= '0;
                byte_cnt     <= '0;
                done         <= 1'b0;
                error        <= 1'b0;
                core_reset_n <= 1'b0;
            end
            if (take) begin
                case (state)
                    CNT_LO: count[7:0] <= rx_data;
                    CNT_HI: begin
                        count[15:8] <= rx_data;
                        if (oversize) error <= 1'b1;
                    end
                    DATA: begin
                        csum     <= csum ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        shreg    <= {rx_data, shreg[23:8]};
                        if (last_byte) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= word_idx[ADDR_W-1:0];
                            mem_wdata <= {rx_data, shreg};
                            word_idx  <= word_idx + 16'd1;
                        end
                    end
                    CHECK: begin
                        if (csum_ok) begin
                            done         <= 1'b1;
                            core_reset_n <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_insn_loader.sv
// Directed bench for insn_loader: framed loads, error frames, garbage
// and asynchronous reset in the middle of a load.
module tb_insn_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_reset_n;
    logic          done;
    logic          error;

    insn_loader #(.MEM_WORDS(1024), .ADDR_W(AW)) dut (
        .clk(clk),
        .reset(reset),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .core_reset_n(core_reset_n),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int ready_bad = 0;
    int both_bad  = 0;
    int rdy_low   = 0;
    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];
    logic [7:0]    tx[$];

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
        if (rx_ready === mem_we) ready_bad++;
        if (done && error) both_bad++;
        if (!rx_ready) rdy_low++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] got_a(input int i);
        return (i < wa.size()) ? 32'(wa[i]) : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] got_d(input int i);
        return (i < wd.size()) ? wd[i] : 32'hxxxx_xxxx;
    endfunction

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n == 8) check("send_timeout_ready", 32'(rx_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_all();
        foreach (tx[i]) send(tx[i]);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_writes();
        wa.delete();
        wd.delete();
    endtask

    initial begin
        #20000;
        $error("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(rx_ready), 32'd1);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_core", 32'(core_reset_n), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // single word
        clear_writes();
        tx = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h80, 8'h60, 8'h01, 8'h72};
        send_all();
        idle(2);
        check("w1_count", wa.size(), 32'd1);
        check("w1_addr", got_a(0), 32'd0);
        check("w1_data", got_d(0), 32'h0160_8093);
        check("w1_done", 32'(done), 32'd1);
        check("w1_error", 32'(error), 32'd0);
        check("w1_core", 32'(core_reset_n), 32'd1);

        // rx_data ignored without rx_valid
        rx_data = 8'hA5;
        idle(3);
        check("novalid_done", 32'(done), 32'd1);
        check("novalid_core", 32'(core_reset_n), 32'd1);

        // three words, rx_valid held high throughout
        clear_writes();
        rdy_low = 0;
        tx = '{8'hA5, 8'h03, 8'h00,
               8'h93, 8'h80, 8'h60, 8'h01,
               8'h13, 8'h81, 8'h20, 8'h01,
               8'h33, 8'hF1, 8'h20, 8'h00, 8'h23};
        send_all();
        idle(2);
        check("w3_count", wa.size(), 32'd3);
        check("w3_a0", got_a(0), 32'd0);
        check("w3_d0", got_d(0), 32'h0160_8093);
        check("w3_a1", got_a(1), 32'd1);
        check("w3_d1", got_d(1), 32'h0120_8113);
        check("w3_a2", got_a(2), 32'd2);
        check("w3_d2", got_d(2), 32'h0020_F133);
        check("w3_stalls", rdy_low, 32'd3);
        check("w3_done", 32'(done), 32'd1);
        check("w3_core", 32'(core_reset_n), 32'd1);

        // count == MEM_WORDS is legal; reset after two data bytes
        clear_writes();
        tx = '{8'hA5, 8'h00, 8'h04};
        send_all();
        check("max_error", 32'(error), 32'd0);
        check("max_done", 32'(done), 32'd0);
        check("max_core", 32'(core_reset_n), 32'd0);
        send(8'h11);
        send(8'h22);
        rx_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_ready", 32'(rx_ready), 32'd1);
        check("mid_we", 32'(mem_we), 32'd0);
        check("mid_addr", 32'(mem_addr), 32'd0);
        check("mid_wdata", mem_wdata, 32'd0);
        check("mid_core", 32'(core_reset_n), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_error", 32'(error), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // leading garbage, then a frame
        tx = '{8'h00, 8'hFF, 8'h5A};
        send_all();
        idle(2);
        check("garb_writes", wa.size(), 32'd0);
        check("garb_done", 32'(done), 32'd0);
        tx = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h81, 8'h20, 8'h01, 8'hB3};
        send_all();
        idle(2);
        check("postrst_count", wa.size(), 32'd1);
        check("postrst_addr", got_a(0), 32'd0);
        check("postrst_data", got_d(0), 32'h0120_8113);
        check("postrst_done", 32'(done), 32'd1);

        // empty frame
        clear_writes();
        tx = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_all();
        idle(2);
        check("empty_writes", wa.size(), 32'd0);
        check("empty_done", 32'(done), 32'd1);
        check("empty_core", 32'(core_reset_n), 32'd1);

        // oversize count 0x0401
        tx = '{8'hA5, 8'h01, 8'h04};
        send_all();
        check("over_error", 32'(error), 32'd1);
        check("over_done", 32'(done), 32'd0);
        check("over_core", 32'(core_reset_n), 32'd0);
        idle(2);
        check("over_writes", wa.size(), 32'd0);

        // bad checksum, then recovery
        clear_writes();
        tx = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h80, 8'h60, 8'h01, 8'h00};
        send_all();
        idle(2);
        check("bad_count", wa.size(), 32'd1);
        check("bad_addr", got_a(0), 32'd0);
        check("bad_error", 32'(error), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_core", 32'(core_reset_n), 32'd0);
        clear_writes();
        send(8'hA5);
        check("rec_err_clr", 32'(error), 32'd0);
        tx = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        send_all();
        idle(2);
        check("rec_count", wa.size(), 32'd1);
        check("rec_addr", got_a(0), 32'd0);
        check("rec_data", got_d(0), 32'hDEAD_BEEF);
        check("rec_done", 32'(done), 32'd1);
        check("rec_core", 32'(core_reset_n), 32'd1);

        check("ready_vs_we", ready_bad, 32'd0);
        check("done_and_error", both_bad, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
